// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak byte-packing front end.
package keccak_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs one byte-stream message big-endian into 32-bit words for the keccak core,
// including the core's end-of-message encoding and buffer_full back-pressure.
//
// state | meaning
// RUN   | accepting message bytes into the accumulator / output slot
// PAD   | message ended on a word boundary; empty final word still to be queued
// FLUSH | final word sits in the slot waiting to be taken
// DONE  | message complete; nothing accepted until reset
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [WORD_W-1:0] in,
    output logic              in_ready,
    output logic              is_last,
    output logic [1:0]        byte_num,
    input  logic              buffer_full,
    output logic              done,
    output logic [CNT_W-1:0]  msg_bytes
);

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [23:0]       acc, acc_nxt;
    logic [WORD_W-1:0] in_nxt, merged;
    logic              in_ready_nxt, is_last_nxt, done_nxt;
    logic [1:0]        byte_num_nxt;
    logic              take, slot_free, accept, word_end;

    assign take      = in_ready & ~buffer_full;
    assign slot_free = ~in_ready | take;
    // Held low during the reset cycle so nothing is accepted from stale state.
    assign s_ready   = (state == RUN) & slot_free & ~reset;
    assign accept    = s_valid & s_ready;
    assign word_end  = (cnt == 2'(BYTES_PER_WORD - 1));

    // Current byte placed after the cnt bytes already held; low bytes stay zero.
    always_comb begin
        merged = '0;
        case (cnt)
            2'd0:    merged = {s_data, 24'h0};
            2'd1:    merged = {acc[23:16], s_data, 16'h0};
            2'd2:    merged = {acc[23:8], s_data, 8'h0};
            default: merged = {acc, s_data};
        endcase
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        in_nxt       = in;
        in_ready_nxt = in_ready;
        is_last_nxt  = is_last;
        byte_num_nxt = byte_num;
        done_nxt     = done;

        // A take empties the slot unless a new word is loaded below.
        if (take) begin
            in_nxt       = '0;
            in_ready_nxt = 1'b0;
            is_last_nxt  = 1'b0;
            byte_num_nxt = 2'd0;
        end

        case (state)
            RUN: begin
                if (accept) begin
                    if (s_last || word_end) begin
                        in_nxt       = merged;
                        in_ready_nxt = 1'b1;
                        is_last_nxt  = s_last & ~word_end;
                        byte_num_nxt = (s_last & ~word_end) ? cnt + 2'd1 : 2'd0;
                        cnt_nxt      = 2'd0;
                        if (s_last)
                            state_nxt = word_end ? PAD : FLUSH;
                    end else begin
                        case (cnt)
                            2'd0:    acc_nxt[23:16] = s_data;
                            2'd1:    acc_nxt[15:8]  = s_data;
                            default: acc_nxt[7:0]   = s_data;
                        endcase
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    in_nxt       = '0;
                    in_ready_nxt = 1'b1;
                    is_last_nxt  = 1'b1;
                    byte_num_nxt = 2'd0;
                    state_nxt    = FLUSH;
                end
            end
            FLUSH: begin
                if (take) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= 2'd0;
            acc       <= '0;
            in        <= '0;
            in_ready  <= 1'b0;
            is_last   <= 1'b0;
            byte_num  <= 2'd0;
            done      <= 1'b0;
            msg_bytes <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            in        <= in_nxt;
            in_ready  <= in_ready_nxt;
            is_last   <= is_last_nxt;
            byte_num  <= byte_num_nxt;
            done      <= done_nxt;
            if (accept && (msg_bytes != '1))
                msg_bytes <= msg_bytes + 1'b1;
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench for keccak_byte_packer against a word-list model of the message.
module tb_keccak_byte_packer;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] w;
        logic        l;
        logic [1:0]  n;
    } wd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [31:0] in;
    logic        in_ready, is_last, done;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic [31:0] msg_bytes;

    logic        s_ready_sat, in_ready_sat, is_last_sat, done_sat;
    logic [31:0] in_sat;
    logic [1:0]  byte_num_sat, msg_bytes_sat;

    int n_checks = 0;
    int n_pass   = 0;
    int inv_err  = 0;
    wd_t obs_q[$];
    wd_t exp_q[$];

    keccak_byte_packer dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .in(in), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full), .done(done), .msg_bytes(msg_bytes)
    );

    // Narrow counter copy to reach the saturation point quickly.
    keccak_byte_packer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_sat), .in(in_sat), .in_ready(in_ready_sat), .is_last(is_last_sat),
        .byte_num(byte_num_sat), .buffer_full(buffer_full), .done(done_sat),
        .msg_bytes(msg_bytes_sat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (in_ready && !buffer_full)
                obs_q.push_back({in, is_last, byte_num});
            if (is_last && !in_ready)
                inv_err++;
            if (!is_last && byte_num != 2'd0)
                inv_err++;
        end
    end

    function automatic void build_model(input bq_t msg);
        int n;
        int k;
        logic [31:0] w;
        n = msg.size();
        exp_q.delete();
        for (int b = 0; b < n; b += 4) begin
            w = '0;
            k = (n - b < 4) ? n - b : 4;
            for (int j = 0; j < k; j++)
                w[31 - 8*j -: 8] = msg[b + j];
            if (k < 4) exp_q.push_back({w, 1'b1, 2'(k)});
            else       exp_q.push_back({w, 1'b0, 2'd0});
        end
        if (n % 4 == 0)
            exp_q.push_back({32'h0, 1'b1, 2'd0});
    endfunction

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; buffer_full = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        obs_q.delete();
    endtask

    task automatic send_msg(input bq_t msg, input int bf_pct, input int valid_pct);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < msg.size() && guard < 4000) begin
            if ($urandom_range(99) < valid_pct) begin
                s_valid = 1'b1; s_data = msg[i]; s_last = (i == msg.size() - 1);
            end else begin
                s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'b0;
            end
            buffer_full = ($urandom_range(99) < bf_pct);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        guard = 0;
        while (!done && guard < 4000) begin
            buffer_full = ($urandom_range(99) < bf_pct);
            @(posedge clk); #1;
            guard++;
        end
        buffer_full = 1'b0;
        n_checks++;
        if (!done) $display("FAIL send_timeout: done=%b required 1", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; buffer_full = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b required 0", s_ready);
        else n_pass++;
        n_checks++;
        if ({in, in_ready, is_last, byte_num, done, msg_bytes} !== 69'h0)
            $display("FAIL reset_outputs: in=%h in_ready=%b is_last=%b byte_num=%0d done=%b msg_bytes=%0d required all 0",
                     in, in_ready, is_last, byte_num, done, msg_bytes);
        else n_pass++;
        s_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_eight_bytes();
        bq_t msg;
        do_reset();
        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        send_msg(msg, 0, 100);
        build_model(msg);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL eight_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL eight_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (msg_bytes !== 32'd8) $display("FAIL eight_msg_bytes: got %0d required 8", msg_bytes);
        else n_pass++;
        n_checks++;
        if (msg_bytes_sat !== 2'd3) $display("FAIL msg_bytes_saturate: got %0d required 3", msg_bytes_sat);
        else n_pass++;
    endtask

    task automatic test_five_bytes();
        bq_t msg;
        do_reset();
        for (int i = 0; i < 5; i++) msg.push_back(8'hA1 + 8'(i));
        send_msg(msg, 0, 100);
        build_model(msg);
        n_checks++;
        if (obs_q.size() !== 2) $display("FAIL five_takes: got %0d required 2", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL five_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [7:0] b3[3];
        b3 = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = b3[k]; s_last = (k == 2);
            @(negedge clk);
            if (k == 2) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL latency_early: in_ready=%b required 0", in_ready);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        n_checks++;
        if ({in_ready, in, is_last, byte_num} !== {1'b1, 32'h11223300, 1'b1, 2'd3})
            $display("FAIL latency_word: in_ready=%b in=%h is_last=%b byte_num=%0d required 1 11223300 1 3",
                     in_ready, in, is_last, byte_num);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) $display("FAIL latency_done: done=%b in_ready=%b required 1 0", done, in_ready);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bq_t msg, rest;
        logic [34:0] held;
        int bad;
        do_reset();
        for (int i = 0; i < 8; i++) msg.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = msg[k]; s_last = 1'b0;
            @(posedge clk); #1;
        end
        buffer_full = 1'b1;
        s_data = msg[4];
        held = {in, is_last, byte_num};
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ({in, is_last, byte_num} !== held || in_ready !== 1'b1 || s_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad);
        else n_pass++;
        for (int i = 4; i < 8; i++) rest.push_back(msg[i]);
        send_msg(rest, 0, 100);
        build_model(msg);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (msg_bytes !== 32'd8) $display("FAIL bp_msg_bytes: got %0d required 8", msg_bytes);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bq_t msg;
        bq_t none;
        int ready_cnt;
        logic [11:0] rdy_pat, exp_pat;
        do_reset();
        ready_cnt = 0;
        rdy_pat = '0;
        exp_pat = '0;
        for (int k = 0; k < 12; k++) begin
            msg.push_back(8'($urandom));
            s_valid = 1'b1; s_data = msg[k]; s_last = (k == 11);
            @(negedge clk);
            if (s_ready) ready_cnt++;
            rdy_pat[k] = in_ready;
            exp_pat[k] = (k > 0) && (k % 4 == 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        n_checks++;
        if (ready_cnt !== 12) $display("FAIL b2b_s_ready: ready %0d of 12 cycles required 12", ready_cnt);
        else n_pass++;
        n_checks++;
        if (rdy_pat !== exp_pat) $display("FAIL b2b_in_ready_pattern: got %b required %b", rdy_pat, exp_pat);
        else n_pass++;
        send_msg(none, 0, 100);
        build_model(msg);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bq_t msg;
        int len;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            msg.delete();
            len = $urandom_range(17, 1);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(msg, 40, 70);
            build_model(msg);
            n_checks++;
            if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d required %0d", it, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_word%0d: got %h required %h", it, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
            n_checks++;
            if (msg_bytes !== 32'(len)) $display("FAIL rand%0d_msg_bytes: got %0d required %0d", it, msg_bytes, len);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bq_t msg;
        int acc_after;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in, in_ready, is_last, byte_num, done, msg_bytes, s_ready} !== 70'h0)
            $display("FAIL midreset_outputs: in=%h in_ready=%b is_last=%b byte_num=%0d done=%b msg_bytes=%0d s_ready=%b required all 0",
                     in, in_ready, is_last, byte_num, done, msg_bytes, s_ready);
        else n_pass++;
        reset = 1'b0;
        obs_q.delete();
        msg.push_back(8'hBB);
        msg.push_back(8'hCC);
        send_msg(msg, 30, 100);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {32'hBBCC0000, 1'b1, 2'd2})
            $display("FAIL midreset_word: got %0d words first %h required 1 word %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 35'h0, {32'hBBCC0000, 1'b1, 2'd2});
        else n_pass++;
        acc_after = 0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1; s_data = 8'($urandom); s_last = (k == 5);
            @(negedge clk);
            if (s_ready) acc_after++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        n_checks++;
        if (acc_after !== 0 || msg_bytes !== 32'd2 || done !== 1'b1)
            $display("FAIL after_done: accepted=%0d msg_bytes=%0d done=%b required 0 2 1", acc_after, msg_bytes, done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_eight_bytes();
        test_five_bytes();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        n_checks++;
        if (inv_err !== 0) $display("FAIL slot_invariants: %0d violations required 0", inv_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
